prbs_link_sequencer: RTL and testbench
======================================

# prbs_link_sequencer

Bring-up and run controller for the single-bank source-synchronous PRBS loopback. It sits between the clocking/bitslice status (PLL lock, receive-ready) and the Tx PRBS generator / Rx PRBS checker. It sequences reset release, generator warm-up, checker seed alignment and the measured run. It also gates error injection, accumulates lane errors and counts test cycles, so software or the bench reads one pass/fail result.

## Interface
Parameters:
- NUM_LANES, 32, number of single-ended data lines checked (each `lane_err` bit is one line)
- WARMUP_CYCLES, 64, cycles the generator runs before the checker is seeded
- SYNC_CYCLES, 16, cycles `seed_load` is held high
- TEST_CYCLES, 0, RUN length in cycles; 0 = unbounded
- TIMEOUT_CYCLES, 65535, maximum wait for lock or rx-ready
- ERR_W, 32, error counter width
- CNT_W, 48, cycle counter width

Ports:
- intTxClk0  in  1  sole clock; all logic on its rising edge
- int_rst  in  1  synchronous, active-high reset
- start  in  1  level; high requests a test, low returns to IDLE from DONE or FAULT
- pll_locked  in  1  XPLL lock
- rx_rdy  in  1  all receive nibbles ready
- lane_err  in  NUM_LANES  per-line mismatch from the checker, one cycle per event
- int_inject_err_p  in  1  synchronous error-injection request level
- tx_en  out  1  enables the PRBS generator
- seed_load  out  1  checker self-seeds from received data
- int_chk  out  1  checker result valid; high only in RUN
- inject_pulse  out  1  one-cycle single-bit-flip command to the generator
- state  out  3  current state encoding
- err_cnt  out  ERR_W  saturating total bit errors
- err_lanes  out  NUM_LANES  sticky per-line error flags
- edge_cnt  out  CNT_W  RUN cycles elapsed
- done  out  1  test completed
- pass  out  1  done with `err_cnt` equal to 0
- fault  out  1  timeout or link loss

## Operation
- States and encodings: IDLE=0, WAIT_LOCK=1, WAIT_RDY=2, WARMUP=3, SYNC=4, RUN=5, DONE=6, FAULT=7.
- IDLE: all counters, `err_lanes`, `done`, `pass` and `fault` are cleared. When `start`=1, go to WAIT_LOCK.
- WAIT_LOCK: when `pll_locked`=1, go to WAIT_RDY. If the timer reaches TIMEOUT_CYCLES, go to FAULT.
- WAIT_RDY: when `rx_rdy`=1, go to WARMUP. If `pll_locked` drops, or the timer reaches TIMEOUT_CYCLES, go to FAULT. The timer restarts at 0 on entry to each wait state.
- WARMUP: `tx_en`=1. After WARMUP_CYCLES cycles, go to SYNC.
- SYNC: `tx_en`=1 and `seed_load`=1 for exactly SYNC_CYCLES cycles, then go to RUN.
- RUN: `tx_en`=1 and `int_chk`=1. `edge_cnt` increments by 1 every cycle.
  - `err_cnt` adds the popcount of `lane_err`, saturating at 2^ERR_W-1.
  - `err_lanes` ORs in `lane_err`.
  - When TEST_CYCLES≠0 and `edge_cnt` reaches TEST_CYCLES, go to DONE.
  - If `pll_locked`=0 or `rx_rdy`=0, go to FAULT.
- DONE: `tx_en`=0, `done`=1, `pass`=(`err_cnt`==0). Counters are held. When `start`=0, go to IDLE.
- FAULT: `tx_en`=0, `fault`=1. Counters are held. When `start`=0, go to IDLE.
- `start`=0 in any state from WAIT_LOCK to RUN aborts to IDLE.
- Injection: a rising edge of `int_inject_err_p` detected while in RUN produces one `inject_pulse` cycle. Edges in any other state are discarded and are not queued.

## Timing
- Reset values: `state`=0 and every output is 0.
- Outputs are registered. A state change is visible 1 cycle after the qualifying input is sampled.
- `lane_err` is counted only on cycles where registered `state`==RUN. The resulting `err_cnt` and `err_lanes` update is visible on the next cycle.
- `inject_pulse` is asserted on the cycle after the edge is sampled.
- On the final RUN cycle, `edge_cnt` reaches TEST_CYCLES and `lane_err` on that same cycle is still counted. The next cycle shows DONE.
- Simultaneous completion and link loss: FAULT wins.
- Link loss in RUN: `lane_err` on the loss cycle is ignored.
- `edge_cnt` and `err_cnt` saturate and do not wrap.
- `int_rst` asserted mid-run forces IDLE and reset values on the next edge, overriding all other inputs.
- Popcount and accumulate complete in a single cycle.

## Test plan
- Lock after 10 cycles, rx_rdy after 20, TEST_CYCLES=1000, no errors -> state sequence 1,2,3,4,5,6; `seed_load` high 16 cycles; `edge_cnt`=1000; `pass`=1.
- `lane_err`=0x0000_0005 for one RUN cycle and 0x8000_0000 for another -> `err_cnt`=3, `err_lanes`=0x8000_0005, `pass`=0 at DONE.
- `pll_locked` never rises, TIMEOUT_CYCLES=100 -> FAULT on cycle 101 after entering WAIT_LOCK; `tx_en` stays 0.
- `rx_rdy` drops at RUN cycle 50 with `lane_err`=0xFFFF_FFFF on that cycle -> FAULT; `err_cnt` unchanged; `edge_cnt`=50.
- `int_inject_err_p` edges in WARMUP and in RUN -> exactly one `inject_pulse`, during RUN, one cycle wide.
- `int_rst` high at RUN cycle 200, then `start` kept high -> IDLE with all outputs 0, followed by a clean restart through WAIT_LOCK.

Source files
------------

// File: rtl/prbs_link_sequencer.sv
// Bring-up and measured-run controller for the PRBS loopback: sequences lock, rx-ready,
// generator warm-up, checker seeding and the run, and accumulates the pass/fail result.
module prbs_link_sequencer #(
  parameter int NUM_LANES      = 32,
  parameter int WARMUP_CYCLES  = 64,
  parameter int SYNC_CYCLES    = 16,
  parameter int TEST_CYCLES    = 0,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ERR_W          = 32,
  parameter int CNT_W          = 48
) (
  input  logic                 intTxClk0,
  input  logic                 int_rst,
  input  logic                 start,
  input  logic                 pll_locked,
  input  logic                 rx_rdy,
  input  logic [NUM_LANES-1:0] lane_err,
  input  logic                 int_inject_err_p,
  output logic                 tx_en,
  output logic                 seed_load,
  output logic                 int_chk,
  output logic                 inject_pulse,
  output logic [2:0]           state,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [NUM_LANES-1:0] err_lanes,
  output logic [CNT_W-1:0]     edge_cnt,
  output logic                 done,
  output logic                 pass,
  output logic                 fault
);

  // state     | meaning
  // IDLE      | counters cleared, waiting for start
  // WAIT_LOCK | waiting for PLL lock (timed)
  // WAIT_RDY  | waiting for rx ready (timed, lock must hold)
  // WARMUP    | generator running, checker not yet seeded
  // SYNC      | checker seeding from received data
  // RUN       | measured run, errors accumulated
  // DONE      | run complete, result held
  // FAULT     | timeout or link loss, result held
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_WARMUP    = 3'd3,
    S_SYNC      = 3'd4,
    S_RUN       = 3'd5,
    S_DONE      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t                 st, st_nxt;
  logic [31:0]            tmr, tmr_nxt;
  logic                   tmr_zero;
  logic                   link_ok;
  logic                   run_end;
  logic                   inj_prev;
  logic [CNT_W-1:0]       edge_inc, edge_nxt;
  logic [ERR_W:0]         pop, err_sum;
  logic [ERR_W-1:0]       err_nxt;
  logic [NUM_LANES-1:0]   lanes_nxt;

  assign state    = st;
  assign tmr_zero = (tmr == '0);
  assign link_ok  = pll_locked & rx_rdy;
  assign edge_inc = (&edge_cnt) ? edge_cnt : edge_cnt + CNT_W'(1);
  assign run_end  = (TEST_CYCLES != 0) && (edge_inc == CNT_W'(TEST_CYCLES));

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:      if (start) st_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (!start)          st_nxt = S_IDLE;
        else if (pll_locked) st_nxt = S_WAIT_RDY;
        else if (tmr_zero)   st_nxt = S_FAULT;
      end
      S_WAIT_RDY: begin
        if (!start)           st_nxt = S_IDLE;
        else if (!pll_locked) st_nxt = S_FAULT;
        else if (rx_rdy)      st_nxt = S_WARMUP;
        else if (tmr_zero)    st_nxt = S_FAULT;
      end
      S_WARMUP: begin
        if (!start)        st_nxt = S_IDLE;
        else if (tmr_zero) st_nxt = S_SYNC;
      end
      S_SYNC: begin
        if (!start)        st_nxt = S_IDLE;
        else if (tmr_zero) st_nxt = S_RUN;
      end
      S_RUN: begin
        // link loss takes precedence over a coincident run completion
        if (!start)        st_nxt = S_IDLE;
        else if (!link_ok) st_nxt = S_FAULT;
        else if (run_end)  st_nxt = S_DONE;
      end
      S_DONE, S_FAULT: if (!start) st_nxt = S_IDLE;
      default:         st_nxt = S_IDLE;
    endcase
  end

  // Down-counter reloaded on every state change; terminal count is zero.
  always_comb begin
    tmr_nxt = tmr_zero ? tmr : tmr - 32'd1;
    if (st_nxt != st) begin
      case (st_nxt)
        S_WAIT_LOCK, S_WAIT_RDY: tmr_nxt = 32'(TIMEOUT_CYCLES);
        S_WARMUP:                tmr_nxt = 32'(WARMUP_CYCLES - 1);
        S_SYNC:                  tmr_nxt = 32'(SYNC_CYCLES - 1);
        default:                 tmr_nxt = '0;
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) pop = pop + (ERR_W+1)'(lane_err[i]);
    err_sum   = {1'b0, err_cnt} + pop;
    err_nxt   = err_cnt;
    lanes_nxt = err_lanes;
    edge_nxt  = edge_cnt;
    if (st_nxt == S_IDLE) begin
      err_nxt   = '0;
      lanes_nxt = '0;
      edge_nxt  = '0;
    end else if (st == S_RUN) begin
      edge_nxt = edge_inc;
      if (link_ok) begin
        err_nxt   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        lanes_nxt = err_lanes | lane_err;
      end
    end
  end

  always_ff @(posedge intTxClk0) begin
    if (int_rst) begin
      st           <= S_IDLE;
      tmr          <= '0;
      inj_prev     <= 1'b0;
      inject_pulse <= 1'b0;
      tx_en        <= 1'b0;
      seed_load    <= 1'b0;
      int_chk      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fault        <= 1'b0;
      err_cnt      <= '0;
      err_lanes    <= '0;
      edge_cnt     <= '0;
    end else begin
      st           <= st_nxt;
      tmr          <= tmr_nxt;
      inj_prev     <= int_inject_err_p;
      inject_pulse <= (st == S_RUN) && int_inject_err_p && !inj_prev;
      tx_en        <= (st_nxt == S_WARMUP) || (st_nxt == S_SYNC) || (st_nxt == S_RUN);
      seed_load    <= (st_nxt == S_SYNC);
      int_chk      <= (st_nxt == S_RUN);
      done         <= (st_nxt == S_DONE);
      pass         <= (st_nxt == S_DONE) && (err_nxt == '0);
      fault        <= (st_nxt == S_FAULT);
      err_cnt      <= err_nxt;
      err_lanes    <= lanes_nxt;
      edge_cnt     <= edge_nxt;
    end
  end

endmodule

// File: tb/tb_prbs_link_sequencer.sv
// Bench for prbs_link_sequencer: directed bring-up scenarios plus randomized runs,
// every cycle compared against a phase/age reference model.
module tb_prbs_link_sequencer;
  localparam int NL    = 32;
  localparam int WARM  = 64;
  localparam int SYNCC = 16;
  localparam int TESTC = 1000;
  localparam int TO    = 100;
  localparam int EW    = 10;
  localparam int CW    = 48;
  localparam longint ERR_MAX  = (longint'(1) << EW) - 1;
  localparam longint EDGE_MAX = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, pll, rdy, inj;
  logic [NL-1:0] lane;
  logic          tx_en, seed_load, int_chk, inject_pulse, done, pass, fault;
  logic [2:0]    state;
  logic [EW-1:0] err_cnt;
  logic [NL-1:0] err_lanes;
  logic [CW-1:0] edge_cnt;

  prbs_link_sequencer #(
    .NUM_LANES(NL), .WARMUP_CYCLES(WARM), .SYNC_CYCLES(SYNCC), .TEST_CYCLES(TESTC),
    .TIMEOUT_CYCLES(TO), .ERR_W(EW), .CNT_W(CW)
  ) dut (
    .intTxClk0(clk), .int_rst(rst), .start(start), .pll_locked(pll), .rx_rdy(rdy),
    .lane_err(lane), .int_inject_err_p(inj), .tx_en(tx_en), .seed_load(seed_load),
    .int_chk(int_chk), .inject_pulse(inject_pulse), .state(state), .err_cnt(err_cnt),
    .err_lanes(err_lanes), .edge_cnt(edge_cnt), .done(done), .pass(pass), .fault(fault)
  );

  // Reference model: phase number plus cycles spent in that phase.
  int          m_state = 0;
  int          m_age   = 0;
  longint      m_err   = 0;
  longint      m_edge  = 0;
  bit [NL-1:0] m_lanes = '0;
  bit          m_inj   = 1'b0;
  bit          m_prev  = 1'b0;

  always @(posedge clk) begin : model
    int          ns;
    longint      e, ed;
    bit [NL-1:0] l;
    ns = m_state; e = m_err; ed = m_edge; l = m_lanes;
    if (rst) begin
      ns = 0; e = 0; ed = 0; l = '0;
    end else begin
      case (m_state)
        0: if (start) ns = 1;
        1: if (!start) ns = 0; else if (pll) ns = 2; else if (m_age == TO) ns = 7;
        2: if (!start) ns = 0; else if (!pll) ns = 7; else if (rdy) ns = 3;
           else if (m_age == TO) ns = 7;
        3: if (!start) ns = 0; else if (m_age == WARM - 1) ns = 4;
        4: if (!start) ns = 0; else if (m_age == SYNCC - 1) ns = 5;
        5: begin
          ed = (ed == EDGE_MAX) ? ed : ed + 1;
          if (!start) ns = 0;
          else if (!(pll && rdy)) ns = 7;
          else begin
            e = e + $countones(lane);
            if (e > ERR_MAX) e = ERR_MAX;
            l = l | lane;
            if (ed == TESTC) ns = 6;
          end
        end
        default: if (!start) ns = 0;
      endcase
      if (ns == 0) begin e = 0; ed = 0; l = '0; end
    end
    m_inj   <= !rst && (m_state == 5) && inj && !m_prev;
    m_prev  <= rst ? 1'b0 : inj;
    m_age   <= (rst || ns != m_state) ? 0 : m_age + 1;
    m_state <= ns;
    m_err   <= e;
    m_edge  <= ed;
    m_lanes <= l;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int seed_hi  = 0;
  int tx_hi    = 0;
  int inj_hi   = 0;
  int last_st  = 0;
  int hist[$];

  task automatic tick();
    logic e_tx, e_pass;
    @(posedge clk);
    #1;
    e_tx   = (m_state >= 3 && m_state <= 5);
    e_pass = (m_state == 6) && (m_err == 0);
    n_checks++;
    if (state !== 3'(m_state) || tx_en !== e_tx || seed_load !== (m_state == 4) ||
        int_chk !== (m_state == 5) || inject_pulse !== m_inj || err_cnt !== EW'(m_err) ||
        err_lanes !== NL'(m_lanes) || edge_cnt !== CW'(m_edge) || done !== (m_state == 6) ||
        pass !== e_pass || fault !== (m_state == 7)) begin
      n_fail++;
      if (n_fail < 30)
        $display("FAIL cycle_cmp t=%0t (actual/expected) state %0d/%0d tx %b/%b seed %b/%b chk %b/%b inj %b/%b err %0d/%0d lanes %h/%h edge %0d/%0d done %b/%b pass %b/%b fault %b/%b",
                 $time, state, m_state, tx_en, e_tx, seed_load, (m_state == 4), int_chk,
                 (m_state == 5), inject_pulse, m_inj, err_cnt, m_err, err_lanes, m_lanes,
                 edge_cnt, m_edge, done, (m_state == 6), pass, e_pass, fault, (m_state == 7));
    end
    seed_hi += int'(seed_load);
    tx_hi   += int'(tx_en);
    inj_hi  += int'(inject_pulse);
    if (int'(state) != last_st) begin
      hist.push_back(int'(state));
      last_st = int'(state);
    end
  endtask

  task automatic expect_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input int target, input int budget, output int cycles);
    cycles = 0;
    while (int'(state) != target && cycles < budget) begin
      tick();
      cycles++;
    end
    if (int'(state) != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_state: actual state %0d required %0d after %0d cycles", state, target, cycles);
    end
  endtask

  task automatic to_idle();
    start = 1'b0; inj = 1'b0; lane = '0;
    tick();
    tick();
  endtask

  initial begin
    int c, hb, sb, tb0, ib;
    longint seq;
    rst = 1'b1; start = 1'b0; pll = 1'b0; rdy = 1'b0; inj = 1'b0; lane = '0;
    tick();
    tick();
    expect_eq("rst_state", state, 0);
    expect_eq("rst_counts", err_cnt + err_lanes + edge_cnt, 0);
    expect_eq("rst_flags", {tx_en, seed_load, int_chk, inject_pulse, done, pass, fault}, 0);
    rst = 1'b0;
    tick();

    // clean bring-up: lock after 10, rx ready after 20
    hb = hist.size(); sb = seed_hi;
    start = 1'b1;
    repeat (10) tick();
    pll = 1'b1;
    repeat (10) tick();
    rdy = 1'b1;
    wait_state(6, 2000, c);
    seq = 0;
    for (int i = hb; i < hist.size(); i++) seq = seq * 10 + hist[i];
    expect_eq("state_sequence", seq, 123456);
    expect_eq("seed_load_cycles", seed_hi - sb, 16);
    expect_eq("clean_edge_cnt", edge_cnt, 1000);
    expect_eq("clean_pass", pass, 1);
    start = 1'b0;
    tick();
    expect_eq("idle_clears_edge", edge_cnt, 0);
    tick();

    // two error events in RUN
    start = 1'b1;
    wait_state(5, 300, c);
    repeat (4) tick();
    lane = 32'h0000_0005;
    tick();
    lane = '0;
    repeat (4) tick();
    lane = 32'h8000_0000;
    tick();
    lane = '0;
    wait_state(6, 2000, c);
    expect_eq("err_cnt_3", err_cnt, 3);
    expect_eq("err_lanes", err_lanes, 64'h8000_0005);
    expect_eq("err_pass", pass, 0);
    to_idle();

    // lock never arrives
    pll = 1'b0; rdy = 1'b0; tb0 = tx_hi;
    start = 1'b1;
    tick();
    expect_eq("enter_wait_lock", state, 1);
    wait_state(7, 300, c);
    expect_eq("timeout_cycles", c, 101);
    expect_eq("timeout_tx_en", tx_hi - tb0, 0);
    to_idle();

    // rx_rdy loss at RUN cycle 50 with all lanes erroring
    pll = 1'b1; rdy = 1'b1; start = 1'b1;
    wait_state(5, 300, c);
    repeat (49) tick();
    rdy = 1'b0; lane = '1;
    tick();
    lane = '0;
    expect_eq("loss_fault", state, 7);
    expect_eq("loss_edge_cnt", edge_cnt, 50);
    expect_eq("loss_err_cnt", err_cnt, 0);
    rdy = 1'b1;
    to_idle();

    // injection edges in WARMUP and RUN
    ib = inj_hi; start = 1'b1;
    wait_state(3, 300, c);
    inj = 1'b1;
    repeat (3) tick();
    inj = 1'b0;
    wait_state(5, 300, c);
    repeat (2) tick();
    inj = 1'b1;
    tick();
    expect_eq("inject_in_run", inject_pulse, 1);
    tick();
    expect_eq("inject_width", inject_pulse, 0);
    inj = 1'b0;
    wait_state(6, 2000, c);
    expect_eq("inject_total", inj_hi - ib, 1);
    to_idle();

    // reset mid-run with start held
    start = 1'b1;
    wait_state(5, 300, c);
    repeat (199) tick();
    rst = 1'b1;
    tick();
    expect_eq("midrst_state", state, 0);
    expect_eq("midrst_counts", err_cnt + err_lanes + edge_cnt, 0);
    expect_eq("midrst_flags", {tx_en, seed_load, int_chk, inject_pulse, done, pass, fault}, 0);
    rst = 1'b0;
    tick();
    expect_eq("restart_state", state, 1);
    wait_state(6, 2000, c);
    expect_eq("restart_edge_cnt", edge_cnt, 1000);
    to_idle();

    // randomized runs: sparse/dense errors, injection toggles, link flaps, aborts
    for (int it = 0; it < 8; it++) begin
      pll = 1'b1; rdy = 1'b1; start = 1'b1;
      for (int cyc = 0; cyc < 1400; cyc++) begin
        if (it % 2 == 1) lane = $urandom;
        else lane = ($urandom_range(0, 19) == 0) ? (NL'(1) << $urandom_range(0, NL - 1)) : '0;
        inj = ($urandom_range(0, 3) == 0);
        if (it >= 4) begin
          pll = ($urandom_range(0, 599) != 0);
          rdy = ($urandom_range(0, 599) != 0);
        end
        if (it == 6 && $urandom_range(0, 299) == 0) start = 1'b0;
        tick();
        if (int'(state) >= 6 || (it == 6 && !start)) break;
      end
      to_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
